stream_mux_rr: RTL and testbench

- Parametrised N-to-1 registered stream multiplexer; successor to the team's combinational 2-to-1 mux.
- Adds a valid/ready handshake on every channel and a one-deep output register.
- Selects either the channel named by an explicit Selector or, in round-robin mode, the next valid channel.
- Sits between multiple producers (e.g. datapath result sources) and a single consumer that may stall.

---
 rtl/stream_mux_rr.sv | 78 +++++++
 tb/tb_stream_mux_rr.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N-to-1 registered stream mux with explicit-select and round-robin arbitration
module stream_mux_rr #(
  parameter int WORD_LENGTH  = 32,
  parameter int NUM_CHANNELS = 4,
  parameter int SEL_WIDTH    = 2
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                Arb_Mode,
  input  logic [SEL_WIDTH-1:0]                Selector,
  input  logic [NUM_CHANNELS-1:0]             In_Valid,
  input  logic [NUM_CHANNELS*WORD_LENGTH-1:0] In_Data,
  output logic [NUM_CHANNELS-1:0]             In_Ready,
  output logic                                Out_Valid,
  output logic [WORD_LENGTH-1:0]              Out_Data,
  output logic [SEL_WIDTH-1:0]                Out_Channel,
  input  logic                                Out_Ready
);

  logic [SEL_WIDTH-1:0]   rr_ptr;
  logic [SEL_WIDTH-1:0]   rr_idx;
  logic [SEL_WIDTH-1:0]   cand;
  logic                   rr_found;
  logic                   cand_ok;
  logic                   load_en;
  logic                   xfer;
  logic [WORD_LENGTH-1:0] sel_data;

  function automatic logic [SEL_WIDTH-1:0] wrap_idx(input logic [SEL_WIDTH-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    return SEL_WIDTH'(s >= NUM_CHANNELS ? s - NUM_CHANNELS : s);
  endfunction

  // first valid channel at or after rr_ptr; scanning farthest-first lets the nearest win
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    for (int k = NUM_CHANNELS - 1; k >= 0; k--) begin
      if (In_Valid[wrap_idx(rr_ptr, k)]) begin
        rr_found = 1'b1;
        rr_idx   = wrap_idx(rr_ptr, k);
      end
    end
  end

  assign load_en  = !Out_Valid || Out_Ready;
  assign cand     = Arb_Mode ? rr_idx : Selector;
  assign cand_ok  = Arb_Mode ? rr_found : (int'(Selector) < NUM_CHANNELS);
  assign In_Ready = (load_en && cand_ok && !reset) ? (NUM_CHANNELS'(1) << cand) : '0;
  assign xfer     = |(In_Valid & In_Ready);

  // In_Ready is one-hot, so masking and OR-ing gives the granted word without an out-of-range index
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_CHANNELS; i++)
      sel_data = sel_data | (In_Data[i*WORD_LENGTH +: WORD_LENGTH] & {WORD_LENGTH{In_Ready[i]}});
  end

  // output register: load on transfer, drain when consumed, hold on stall
  always_ff @(posedge clk) begin
    if (reset) begin
      Out_Valid   <= 1'b0;
      Out_Data    <= '0;
      Out_Channel <= '0;
      rr_ptr      <= '0;
    end else if (xfer) begin
      Out_Valid   <= 1'b1;
      Out_Data    <= sel_data;
      Out_Channel <= cand;
      if (Arb_Mode)
        rr_ptr <= (int'(cand) == NUM_CHANNELS - 1) ? '0 : cand + 1'b1;
    end else if (Out_Ready) begin
      Out_Valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stream_mux_rr.sv
// tb_stream_mux_rr: directed checks of the 4-channel and 3-channel stream mux
module tb_stream_mux_rr;

  logic        clk = 1'b0;
  logic        rst, mode, ordy, ov;
  logic [1:0]  sel, och;
  logic [3:0]  iv, rdy;
  logic [31:0] od;
  logic [31:0] d4 [4];

  logic        rst3, mode3, ordy3, ov3;
  logic [1:0]  sel3, och3;
  logic [2:0]  iv3, rdy3;
  logic [31:0] od3;
  logic [31:0] d3 [3];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  stream_mux_rr #(.WORD_LENGTH(32), .NUM_CHANNELS(4), .SEL_WIDTH(2)) u_dut (
    .clk(clk), .reset(rst), .Arb_Mode(mode), .Selector(sel), .In_Valid(iv),
    .In_Data({d4[3], d4[2], d4[1], d4[0]}), .In_Ready(rdy), .Out_Valid(ov),
    .Out_Data(od), .Out_Channel(och), .Out_Ready(ordy)
  );

  stream_mux_rr #(.WORD_LENGTH(32), .NUM_CHANNELS(3), .SEL_WIDTH(2)) u_dut3 (
    .clk(clk), .reset(rst3), .Arb_Mode(mode3), .Selector(sel3), .In_Valid(iv3),
    .In_Data({d3[2], d3[1], d3[0]}), .In_Ready(rdy3), .Out_Valid(ov3),
    .Out_Data(od3), .Out_Channel(och3), .Out_Ready(ordy3)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; mode = 1'b1; sel = 2'd0; iv = 4'b1111; ordy = 1'b1;
    for (int i = 0; i < 4; i++) d4[i] = 32'hA5A5_0000 | 32'(i);
    rst3 = 1'b1; mode3 = 1'b0; sel3 = 2'd0; iv3 = 3'b000; ordy3 = 1'b1;
    for (int i = 0; i < 3; i++) d3[i] = 32'hB0B0_0000 | 32'(i);

    for (int c = 0; c < 2; c++) begin
      tick();
      check("rst_rdy", 64'(rdy), 64'h0);
      check("rst_ov", 64'(ov), 64'h0);
      check("rst_od", 64'(od), 64'h0);
      check("rst_och", 64'(och), 64'h0);
    end

    rst = 1'b0;
    #1;
    check("rel_rdy", 64'(rdy), 64'b0001);
    for (int k = 0; k < 8; k++) begin
      tick();
      check("rr4_ov", 64'(ov), 64'h1);
      check("rr4_och", 64'(och), 64'(k % 4));
      check("rr4_od", 64'(od), 64'(32'hA5A5_0000 | 32'(k % 4)));
    end

    iv = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("rr2_och", 64'(och), (k % 2 == 1) ? 64'd3 : 64'd1);
    end

    mode = 1'b0; sel = 2'd2; iv = 4'b0100;
    #1;
    check("sel_rdy", 64'(rdy), 64'b0100);
    tick();
    check("sel_ov", 64'(ov), 64'h1);
    check("sel_od", 64'(od), 64'hA5A5_0002);
    check("sel_och", 64'(och), 64'd2);
    iv = 4'b0000;
    #1;
    check("sel_rdy_noval", 64'(rdy), 64'b0100);
    tick();
    check("drain_ov", 64'(ov), 64'h0);
    check("drain_od", 64'(od), 64'hA5A5_0002);

    d4[1] = 32'h1234_5678; sel = 2'd1; iv = 4'b0010;
    tick();
    check("bp_load_od", 64'(od), 64'h1234_5678);
    ordy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      iv = (k == 1) ? 4'b0101 : ((k == 0) ? 4'b1111 : 4'b1010);
      sel = 2'(k);
      mode = k[0];
      d4[1] = 32'hDEAD_0000 | 32'(k);
      #1;
      check("bp_rdy", 64'(rdy), 64'h0);
      tick();
      check("bp_ov", 64'(ov), 64'h1);
      check("bp_od", 64'(od), 64'h1234_5678);
      check("bp_och", 64'(och), 64'd1);
    end
    d4[1] = 32'hA5A5_0001; ordy = 1'b1; mode = 1'b1; iv = 4'b1000;
    #1;
    check("bp_release_rdy", 64'(rdy), 64'b1000);
    tick();
    check("bp_release_ov", 64'(ov), 64'h1);
    check("bp_release_och", 64'(och), 64'd3);
    check("bp_release_od", 64'(od), 64'hA5A5_0003);

    iv = 4'b0010;
    #1;
    check("pre_rst_rdy", 64'(rdy), 64'b0010);
    tick();
    check("pre_rst_och", 64'(och), 64'd1);
    ordy = 1'b0; iv = 4'b0001;
    tick();
    check("stall_ov", 64'(ov), 64'h1);
    check("stall_och", 64'(och), 64'd1);
    rst = 1'b1;
    #1;
    check("midrst_rdy", 64'(rdy), 64'h0);
    tick();
    check("midrst_ov", 64'(ov), 64'h0);
    rst = 1'b0; ordy = 1'b1; iv = 4'b0110;
    #1;
    check("post_rst_ptr_rdy", 64'(rdy), 64'b0010);
    tick();
    check("post_rst_och", 64'(och), 64'd1);
    iv = 4'b1000;
    #1;
    check("post_rst_rdy3", 64'(rdy), 64'b1000);
    tick();
    check("post_rst_och3", 64'(och), 64'd3);
    check("post_rst_ov", 64'(ov), 64'h1);

    check("n3_rst_ov", 64'(ov3), 64'h0);
    rst3 = 1'b0; sel3 = 2'd0; iv3 = 3'b001;
    #1;
    check("n3_sel0_rdy", 64'(rdy3), 64'b001);
    tick();
    check("n3_sel0_ov", 64'(ov3), 64'h1);
    check("n3_sel0_od", 64'(od3), 64'hB0B0_0000);
    sel3 = 2'd3; iv3 = 3'b111;
    #1;
    check("n3_sel3_rdy", 64'(rdy3), 64'h0);
    tick();
    check("n3_sel3_ov", 64'(ov3), 64'h0);
    mode3 = 1'b1;
    #1;
    check("n3_rr_rdy", 64'(rdy3), 64'b001);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("n3_rr_och", 64'(och3), 64'(k % 3));
      check("n3_rr_od", 64'(od3), 64'(32'hB0B0_0000 | 32'(k % 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
